// File: rtl/error_accumulator_pkg.sv
// Shared widths, derived datapath sizes and FSM state type for the SSE accumulator.
package err_pkg;
  localparam int unsigned DW    = 20;
  localparam int unsigned FRAC  = 10;
  localparam int unsigned ACC_W = 40;
  localparam int unsigned N     = 150;
  localparam int unsigned CNT_W = 8;
  // residual width and width of the squared residual after the FRAC shift
  localparam int unsigned RW    = DW + 2;
  localparam int unsigned QW    = 2 * RW - FRAC;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/error_accumulator_if.sv
// Control, sample and result signals between the loader/coefficient side and the accumulator.
interface error_accumulator_if #(
  parameter int unsigned DW    = err_pkg::DW,
  parameter int unsigned ACC_W = err_pkg::ACC_W,
  parameter int unsigned CNT_W = err_pkg::CNT_W
);
  logic                    start;
  logic                    en;
  logic signed [DW-1:0]    x;
  logic signed [DW-1:0]    y;
  logic signed [DW-1:0]    B0;
  logic signed [DW-1:0]    B1;
  logic        [ACC_W-1:0] err;
  logic        [CNT_W-1:0] count;
  logic                    busy;
  logic                    done;
  logic                    sat;

  modport master (output start, en, x, y, B0, B1,
                  input  err, count, busy, done, sat);
  modport slave  (input  start, en, x, y, B0, B1,
                  output err, count, busy, done, sat);
endinterface

// File: rtl/error_accumulator_residual_sq_pipe.sv
// Input capture plus S1-S3: prediction, residual and truncated square, one sample per cycle.
module residual_sq_pipe
  import err_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] x,
  input  logic signed [DW-1:0] y,
  input  logic signed [DW-1:0] b0,
  input  logic signed [DW-1:0] b1,
  output logic                 out_valid,
  output logic        [QW-1:0] q
);
  logic                   v0_q, v1_q, v2_q, v3_q;
  logic signed [DW-1:0]   x0_q, y0_q, y1_q;
  logic signed [DW:0]     pred1_q, pred1_d;
  logic signed [RW-1:0]   r2_q, r2_d;
  logic        [QW-1:0]   q3_q, q3_d;
  logic signed [2*DW-1:0] p;
  logic signed [2*RW-1:0] sq;

  always_comb begin
    p       = b1 * x0_q;
    // the shifted product is deliberately wrapped to DW+1 bits before the add
    pred1_d = $signed({b0[DW-1], b0}) + (DW+1)'(p >>> FRAC);
    r2_d    = $signed({{2{y1_q[DW-1]}}, y1_q}) - $signed({pred1_q[DW], pred1_q});
    sq      = r2_q * r2_q;
    q3_d    = QW'($unsigned(sq) >> FRAC);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      v0_q <= in_valid;
      v1_q <= v0_q;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  always_ff @(posedge clk) begin
    x0_q    <= x;
    y0_q    <= y;
    y1_q    <= y0_q;
    pred1_q <= pred1_d;
    r2_q    <= r2_d;
    q3_q    <= q3_d;
  end

  assign out_valid = v3_q;
  assign q         = q3_q;
endmodule

// File: rtl/error_accumulator.sv
// Run control, sample counter, coefficient latches and saturating SSE accumulator.
module error_accumulator #(
  parameter int unsigned N     = err_pkg::N,
  parameter int unsigned CNT_W = err_pkg::CNT_W,
  parameter int unsigned ACC_W = err_pkg::ACC_W
) (
  input  logic               clk,
  input  logic               rst,
  error_accumulator_if.slave bus
);
  import err_pkg::*;

  localparam int unsigned SW = ((ACC_W > QW) ? ACC_W : QW) + 1;
  localparam logic [SW-1:0] ERR_MAX = {{(SW-ACC_W){1'b0}}, {ACC_W{1'b1}}};

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      ret_q, ret_d;
  logic [ACC_W-1:0]      err_q, err_d;
  logic                  sat_q, sat_d;
  logic signed [DW-1:0]  b0_q, b1_q;
  logic                  accept;
  logic                  pv;
  logic [QW-1:0]         pq;
  logic [SW-1:0]         sum;

  residual_sq_pipe u_pipe (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.start),
    .in_valid  (accept),
    .x         (bus.x),
    .y         (bus.y),
    .b0        (b0_q),
    .b1        (b1_q),
    .out_valid (pv),
    .q         (pq)
  );

  always_comb begin
    accept  = (state_q == RUN) && bus.en && !bus.start && (count_q < CNT_W'(N));
    sum     = SW'(err_q) + SW'(pq);
    state_d = state_q;
    count_d = count_q;
    ret_d   = ret_q;
    err_d   = err_q;
    sat_d   = sat_q;
    if (bus.start) begin
      state_d = RUN;
      count_d = '0;
      ret_d   = '0;
      err_d   = '0;
      sat_d   = 1'b0;
    end else begin
      if (accept) begin
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(N - 1)) state_d = DRAIN;
      end
      // retired samples are counted so DRAIN knows when the last one has landed
      if (pv) begin
        ret_d = ret_q + CNT_W'(1);
        if (sum > ERR_MAX) begin
          err_d = '1;
          sat_d = 1'b1;
        end else begin
          err_d = ACC_W'(sum);
        end
        if (state_q == DRAIN && ret_q == CNT_W'(N - 1)) state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      ret_q   <= '0;
      err_q   <= '0;
      sat_q   <= 1'b0;
      b0_q    <= '0;
      b1_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ret_q   <= ret_d;
      err_q   <= err_d;
      sat_q   <= sat_d;
      if (bus.start) begin
        b0_q <= bus.B0;
        b1_q <= bus.B1;
      end
    end
  end

  assign bus.err   = err_q;
  assign bus.count = count_q;
  assign bus.busy  = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done  = (state_q == DONE);
  assign bus.sat   = sat_q;
endmodule
